ascii_stream_arbiter: RTL and testbench

Merges several independent ASCII requester streams (e.g. UART receiver, boot-message ROM, status reporter) onto the single `ascii`/`ascii_val` input of the character buffer. Grants are round-robin, and a grant is held for a whole line so that text from different sources is never interleaved mid-line. A grant is released on a line terminator or after an idle timeout. The output is registered; the character buffer accepts every cycle, so the downstream side has no backpressure.

---
 rtl/ascii_stream_arbiter.sv | 143 ++++++++++++++
 tb/tb_ascii_stream_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_stream_arbiter.sv
// rtl/ascii_stream_arbiter.sv - round-robin, line-locked merge of ASCII requester streams
module ascii_stream_arbiter #(
    parameter int p_num_reqs = 2,
    parameter int p_timeout  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*p_num_reqs-1:0] req_ascii,
    input  logic [p_num_reqs-1:0]   req_val,
    output logic [p_num_reqs-1:0]   req_rdy,
    output logic [7:0]              ascii,
    output logic                    ascii_val,
    output logic [$clog2(p_num_reqs)-1:0] grant_idx,
    output logic                    locked
);
    localparam int iw = $clog2(p_num_reqs);
    localparam int cw = $clog2(p_timeout + 1);

    typedef enum logic {
        st_idle   = 1'b0,
        st_locked = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [iw-1:0]   ptr;
    logic [iw-1:0]   owner;
    logic [iw-1:0]   grant_q;
    logic [cw-1:0]   idle_cnt;

    logic [iw-1:0]   winner;
    logic            found;
    int              scan_idx;
    logic [iw-1:0]   sel;
    logic            xfer;
    logic [7:0]      xfer_char;
    logic            is_term;
    logic            timeout_hit;

    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    function automatic logic [iw-1:0] wrap_inc(input logic [iw-1:0] i);
        return (i == iw'(p_num_reqs - 1)) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < p_num_reqs; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= p_num_reqs) begin
                scan_idx = scan_idx - p_num_reqs;
            end
            if (!found && req_val[scan_idx]) begin
                found  = 1'b1;
                winner = iw'(scan_idx);
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        sel     = (state == st_locked) ? owner : winner;
        if (state == st_locked) begin
            req_rdy[owner] = req_val[owner];
        end else if (found) begin
            req_rdy[winner] = 1'b1;
        end
    end

    assign xfer        = |(req_val & req_rdy);
    assign xfer_char   = req_ascii[8*sel +: 8];
    assign is_term     = (xfer_char == 8'h0A) || (xfer_char == 8'h1B);
    assign timeout_hit = (idle_cnt == cw'(p_timeout - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: begin
                if (xfer && !is_term) begin
                    state_nxt = st_locked;
                end
            end
            st_locked: begin
                if ((xfer && is_term) || (!xfer && timeout_hit)) begin
                    state_nxt = st_idle;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // A reset in the middle of a transfer drops that character.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            owner     <= '0;
            grant_q   <= '0;
            idle_cnt  <= '0;
            ascii     <= 8'h00;
            ascii_val <= 1'b0;
        end else begin
            ascii_val <= xfer;
            if (xfer) begin
                ascii <= xfer_char;
            end
            if (state == st_idle) begin
                if (xfer) begin
                    grant_q <= winner;
                    if (is_term) begin
                        ptr <= wrap_inc(winner);
                    end else begin
                        owner    <= winner;
                        idle_cnt <= '0;
                    end
                end
            end else begin
                if (xfer) begin
                    if (is_term) begin
                        ptr <= wrap_inc(owner);
                    end else begin
                        idle_cnt <= '0;
                    end
                end else if (timeout_hit) begin
                    ptr <= wrap_inc(owner);
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

    assign grant_idx = grant_q;
    assign locked    = (state == st_locked);

endmodule

// File: tb/tb_ascii_stream_arbiter.sv
// tb/tb_ascii_stream_arbiter.sv - model-checked bench for ascii_stream_arbiter
module tb_ascii_stream_arbiter;
    localparam int N  = 3;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*N-1:0] req_ascii = '0;
    logic [N-1:0]   req_val = '0;
    logic [N-1:0]   req_rdy;
    logic [7:0]     ascii;
    logic           ascii_val;
    logic [1:0]     grant_idx;
    logic           locked;

    int vectors = 0;
    int miscompares = 0;

    ascii_stream_arbiter #(.p_num_reqs(N), .p_timeout(TO)) dut (
        .clk(clk), .rst(rst), .req_ascii(req_ascii), .req_val(req_val),
        .req_rdy(req_rdy), .ascii(ascii), .ascii_val(ascii_val),
        .grant_idx(grant_idx), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, owner, rotation start, and a count of idle cycles.
    bit         armed = 0;
    bit         m_lock = 0;
    int         m_owner = 0, m_ptr = 0, m_idle = 0, m_grant = 0;
    logic [7:0] m_ascii = 8'h00;
    bit         m_val = 0;
    logic [N-1:0] last_xfer = '0;

    always @(negedge clk) begin
        logic [N-1:0] er;
        int who;
        int j;
        logic [7:0] d;
        bit term;
        er = '0;
        who = -1;
        if (!m_lock) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (who < 0 && req_val[j]) who = j;
            end
        end else if (req_val[m_owner]) begin
            who = m_owner;
        end
        if (who >= 0) er[who] = 1'b1;
        if (armed) begin
            chk("req_rdy", int'(req_rdy), int'(er));
            chk("ascii_val", int'(ascii_val), int'(m_val));
            chk("ascii", int'(ascii), int'(m_ascii));
            chk("grant_idx", int'(grant_idx), m_grant);
            chk("locked", int'(locked), int'(m_lock));
        end
        last_xfer = req_val & req_rdy;
        d = (who >= 0) ? req_ascii[8*who +: 8] : 8'h00;
        term = (d == 8'h0A) || (d == 8'h1B);
        if (rst) begin
            m_lock = 0; m_owner = 0; m_ptr = 0; m_idle = 0; m_grant = 0;
            m_ascii = 8'h00; m_val = 0;
            armed = 1;
        end else begin
            m_val = (who >= 0);
            if (who >= 0) m_ascii = d;
            if (!m_lock) begin
                if (who >= 0) begin
                    m_grant = who;
                    if (term) m_ptr = (who + 1) % N;
                    else begin m_lock = 1; m_owner = who; m_idle = 0; end
                end
            end else if (who >= 0) begin
                if (term) begin m_lock = 0; m_ptr = (m_owner + 1) % N; end
                else m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_lock = 0; m_ptr = (m_owner + 1) % N; end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [7:0] c0,
                         input logic [7:0] c1, input logic [7:0] c2);
        req_val = v;
        req_ascii = {c2, c1, c0};
        #1;
    endtask

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: return 8'h0A;
            1: return 8'h1B;
            2: return 8'h7F;
            default: return 8'h61 + 8'($urandom_range(0, 25));
        endcase
    endfunction

    initial begin
        // Reset with every requester valid.
        drive('1, 8'h5A, 8'h5A, 8'h5A);
        tick();
        tick();
        chk("rst_ascii_val", int'(ascii_val), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_grant", int'(grant_idx), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", int'(req_rdy), 3'b001);
        drive('0, 8'h00, 8'h00, 8'h00);

        // Line lock: req0 "AB\n" while req1 holds 'x'.
        drive(3'b011, 8'h41, 8'h78, 8'h00);
        chk("ll_rdy0", int'(req_rdy), 3'b001);
        tick();
        chk("ll_A", int'(ascii), 8'h41);
        chk("ll_lock", int'(locked), 1);
        drive(3'b011, 8'h42, 8'h78, 8'h00);
        chk("ll_rdy1", int'(req_rdy), 3'b001);
        tick();
        chk("ll_B", int'(ascii), 8'h42);
        drive(3'b011, 8'h0A, 8'h78, 8'h00);
        chk("ll_rdy2", int'(req_rdy), 3'b001);
        tick();
        chk("ll_LF", int'(ascii), 8'h0A);
        chk("ll_unlock", int'(locked), 0);
        drive(3'b010, 8'h00, 8'h78, 8'h00);
        chk("ll_rdy3", int'(req_rdy), 3'b010);
        tick();
        chk("ll_x", int'(ascii), 8'h78);
        chk("ll_grant1", int'(grant_idx), 1);
        drive(3'b010, 8'h00, 8'h0A, 8'h00);
        tick();
        drive('0, 8'h00, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin: everyone sends LF continuously.
        drive(3'b111, 8'h0A, 8'h0A, 8'h0A);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_grant", int'(grant_idx), i % 3);
            chk("rr_val", int'(ascii_val), 1);
        end
        drive('0, 8'h00, 8'h00, 8'h00);

        // Timeout: req0 sends 'A' then goes quiet; req1 waits with 'y'.
        drive(3'b011, 8'h41, 8'h79, 8'h00);
        tick();
        drive(3'b010, 8'h00, 8'h79, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_held", int'(locked), 1);
        end
        tick();
        chk("to_released", int'(locked), 0);
        chk("to_rdy1", int'(req_rdy), 3'b010);
        tick();
        chk("to_y", int'(ascii), 8'h79);
        chk("to_grant", int'(grant_idx), 1);

        // Timeout race: owner 1 transfers exactly on idle cycle 4.
        drive('0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        drive(3'b010, 8'h00, 8'h7A, 8'h00);
        tick();
        chk("race_val", int'(ascii_val), 1);
        chk("race_z", int'(ascii), 8'h7A);
        chk("race_lock", int'(locked), 1);
        drive('0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        chk("race_restart", int'(locked), 1);
        tick();
        chk("race_release", int'(locked), 0);

        // DEL keeps the lock, ESC releases it (ptr now 2).
        drive(3'b100, 8'h00, 8'h00, 8'h41);
        tick();
        drive(3'b100, 8'h00, 8'h00, 8'h7F);
        tick();
        chk("del_lock", int'(locked), 1);
        drive(3'b100, 8'h00, 8'h00, 8'h1B);
        tick();
        chk("esc_unlock", int'(locked), 0);
        chk("esc_char", int'(ascii), 8'h1B);

        // Mid-line reset discards the in-flight character.
        drive(3'b001, 8'h41, 8'h00, 8'h00);
        tick();
        chk("mr_lock", int'(locked), 1);
        drive(3'b001, 8'h42, 8'h00, 8'h00);
        rst = 1'b1;
        tick();
        chk("mr_unlock", int'(locked), 0);
        chk("mr_noval", int'(ascii_val), 0);
        rst = 1'b0;
        drive('0, 8'h00, 8'h00, 8'h00);

        // Randomized traffic with activity phases and occasional resets.
        begin
            int prob;
            logic [N-1:0] v;
            logic [8*N-1:0] dat;
            prob = 50;
            v = '0;
            dat = '0;
            for (int c = 0; c < 4000; c++) begin
                if (c % 50 == 0) begin
                    case ($urandom_range(0, 2))
                        0: prob = 5;
                        1: prob = 50;
                        default: prob = 95;
                    endcase
                end
                for (int i = 0; i < N; i++) begin
                    if (last_xfer[i]) v[i] = 1'b0;
                    if (!v[i] && ($urandom_range(0, 99) < prob)) begin
                        v[i] = 1'b1;
                        dat[8*i +: 8] = rand_char();
                    end
                end
                rst = ($urandom_range(0, 299) == 0);
                req_val = v;
                req_ascii = dat;
                tick();
            end
            rst = 1'b0;
            req_val = '0;
            tick();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
